rpsc_startup_sequencer: RTL and testbench
=========================================

// Module: rpsc_startup_sequencer
// PURPOSE
//  Command side of the RF power-supply interlock card. Sequences supply turn-on (G2 PS, then drive amp)
//  from operator on/off requests, waits on the card's active-low status returns with timeouts,
//  and latches the first fault. Its outputs drive the card's G2_PS_ACT and DR_AMP inputs.
// PARAMETERS
//  CNT_W       21       width of the shared state timer
//  G2_TMO      1562500  cycles allowed in G2_ON for not_g2_ok to fall (2 s at 1.28 us)
//  DR_TMO      781250   cycles allowed in DR_ON for not_dr_amp_ok to fall
//  OFF_DLY     78125    cycles G2 stays on after drive amp drops in SHUTDOWN
//  DEB_LEN     8        debounce length, used only with RPSC_SEQ_DEBOUNCE_EN
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-low reset
//  on_req          in   1  start request, level, sampled each cycle
//  off_req         in   1  stop request, level
//  fault_clr       in   1  clear latched fault
//  not_on_perm     in   1  card ON permission, active-low (1 = no permission)
//  not_g2_ok       in   1  card G2 ready, active-low
//  not_dr_amp_ok   in   1  card drive-amp ready, active-low
//  g2_ps_act       out  1  G2 PS enable to card
//  dr_amp          out  1  drive-amp enable to card
//  running         out  1  sequence complete, RUN state
//  fault           out  1  latched fault present
//  fault_code      out  3  first-fault code (rpsc_seq_pkg::fault_e)
//  state           out  3  current state, debug
// BEHAVIOUR
//  - Status inputs pass through 2-FF synchronizers reset to 1 (safe = not OK). All outputs registered.
//  - Reset: state=IDLE, all outputs 0, fault_code=NONE, timer=0. Reset mid-sequence drops enables at once.
//  - Timer clears on every state change and counts +1/cycle, saturating. Timeout = timer reaches TMO-1 while
//    the exit condition is false. Success and timeout in the same cycle: success wins.
//  - Priority in each cycle: fault > off_req > forward progress. In IDLE, on_req and off_req together: stay IDLE.
//  States / transitions (enable outputs shown as g2,dr):
//   IDLE (0,0): on_req & !off_req -> G2_ON if not_on_perm=0, else FAULT(NO_PERM=1).
//   G2_ON (1,0): not_on_perm=1 -> FAULT(PERM_LOST=2). Timeout -> FAULT(G2_TMO=3).
//     off_req -> SHUTDOWN. not_g2_ok=0 -> DR_ON.
//   DR_ON (1,1): perm lost -> FAULT(2). not_g2_ok=1 -> FAULT(G2_LOST=5).
//     Timeout -> FAULT(DR_TMO=4). off_req -> SHUTDOWN. not_dr_amp_ok=0 -> RUN.
//   RUN (1,1), running=1: perm lost -> FAULT(2). G2 lost -> FAULT(5).
//     not_dr_amp_ok=1 -> FAULT(DR_LOST=6). off_req -> SHUTDOWN.
//   SHUTDOWN (1,0): timer reaches OFF_DLY-1 -> IDLE. Faults are ignored, since shutdown is already in progress.
//   FAULT (0,0), fault=1: fault_code is written only on entry. It is held until exit.
//     fault_clr & not_on_perm=0 -> IDLE, code cleared. on_req is ignored.
//  - Fault-code priority when several occur in one cycle: PERM_LOST > G2_LOST > DR_LOST > timeout.
//  - Input-to-output latency is 1 cycle from synchronized input to registered output, 3 cycles from the pin.
// CONFIGURATION
//  RPSC_SEQ_DEBOUNCE_EN defined: each synchronized status input feeds a filter.
//    The filtered value changes only after DEB_LEN consecutive equal samples. Filter resets to 1.
//    Adds DEB_LEN cycles of latency.
//  RPSC_SEQ_DEBOUNCE_EN undefined: there is no filter. DEB_LEN is unused. The synchronizer output is used directly.
// STRUCTURE
//  rpsc_seq_pkg:
//    - state_e: IDLE=0, G2_ON=1, DR_ON=2, RUN=3, SHUTDOWN=4, FAULT=5
//    - fault_e: NONE=0 .. DR_LOST=6
//  Sub-module rpsc_seq_debounce (WIDTH=1, LEN), instantiated 3x under the macro.
//  The FSM and shared timer stay in the top module.
// TESTING (G2_TMO=16, DR_TMO=8, OFF_DLY=4, DEB_LEN=4)
//  1. Normal start:
//     - perm=0, pulse on_req. not_g2_ok falls at 5 cycles, not_dr_amp_ok falls at 3 cycles.
//     - Required: g2 then dr then running=1, fault=0.
//  2. G2 timeout: not_g2_ok held 1 -> after 16 cycles in G2_ON, fault=1, code=3, g2_ps_act=0.
//  3. Perm loss in RUN: not_on_perm=1 -> next state FAULT, code=2, both enables 0.
//     fault_clr with perm still 1 -> stays FAULT.
//  4. Shutdown: off_req in RUN -> dr_amp=0 at once, g2_ps_act=0 after 4 cycles, then IDLE.
//  5. Simultaneous events:
//     - In DR_ON, not_dr_amp_ok falls in the same cycle the timer hits 7 -> RUN, no fault.
//     - not_g2_ok=1 and off_req together -> FAULT code 5.
//  6. Reset in RUN: reset=0 asynchronously clears all outputs. With RPSC_SEQ_DEBOUNCE_EN, a 2-cycle glitch
//     on not_g2_ok in RUN causes no fault.

Source files
------------

// File: rtl/rpsc_seq_pkg.sv
// rpsc_seq_pkg: state and first-fault encodings shared by the RF PS startup sequencer.
package rpsc_seq_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    G2_ON    = 3'd1,
    DR_ON    = 3'd2,
    RUN      = 3'd3,
    SHUTDOWN = 3'd4,
    FAULT    = 3'd5
  } state_e;
  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_NO_PERM   = 3'd1,
    FLT_PERM_LOST = 3'd2,
    FLT_G2_TMO    = 3'd3,
    FLT_DR_TMO    = 3'd4,
    FLT_G2_LOST   = 3'd5,
    FLT_DR_LOST   = 3'd6
  } fault_e;
endpackage

// File: rtl/rpsc_seq_debounce.sv
// rpsc_seq_debounce: output follows the input only after LEN consecutive equal samples; resets to all-ones.
module rpsc_seq_debounce #(
  parameter int WIDTH = 1,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam int CW = $clog2(LEN + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  always_comb begin
    cnt_d = (d_i == val_q || cnt_q == CW'(LEN - 1)) ? '0 : cnt_q + 1'b1;
    val_d = (d_i != val_q && cnt_q == CW'(LEN - 1)) ? d_i : val_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      val_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end
  assign q_o = val_q;
endmodule

// File: rtl/rpsc_startup_sequencer.sv
// rpsc_startup_sequencer: G2 PS / drive-amp turn-on sequencer with timeouts and first-fault latch.
// Define RPSC_SEQ_DEBOUNCE_EN to filter the synchronized status returns through rpsc_seq_debounce.
module rpsc_startup_sequencer
  import rpsc_seq_pkg::*;
#(
  parameter int CNT_W   = 21,
  parameter int G2_TMO  = 1562500,
  parameter int DR_TMO  = 781250,
  parameter int OFF_DLY = 78125,
  parameter int DEB_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_req,
  input  logic       off_req,
  input  logic       fault_clr,
  input  logic       not_on_perm,
  input  logic       not_g2_ok,
  input  logic       not_dr_amp_ok,
  output logic       g2_ps_act,
  output logic       dr_amp,
  output logic       running,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
);
  localparam logic [CNT_W-1:0] G2_LIM  = CNT_W'(G2_TMO - 1);
  localparam logic [CNT_W-1:0] DR_LIM  = CNT_W'(DR_TMO - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_DLY - 1);

  if (G2_TMO < 1 || DR_TMO < 1 || OFF_DLY < 1 || DEB_LEN < 1) begin : g_bad_param
    $error("rpsc_startup_sequencer: timing parameters must be at least 1");
  end

  // Status returns are active-low, so reset the synchronizers to 1 (not OK).
  logic [2:0] meta_q, sync_q, stat;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= {not_on_perm, not_g2_ok, not_dr_amp_ok};
      sync_q <= meta_q;
    end
  end

`ifdef RPSC_SEQ_DEBOUNCE_EN
  for (genvar i = 0; i < 3; i++) begin : g_deb
    rpsc_seq_debounce #(.WIDTH(1), .LEN(DEB_LEN)) u_deb (
      .clk  (clk),
      .reset(reset),
      .d_i  (sync_q[i]),
      .q_o  (stat[i])
    );
  end
`else
  assign stat = sync_q;
`endif

  logic perm_n, g2_n, dr_n;
  assign {perm_n, g2_n, dr_n} = stat;

  state_e           state_q, state_d;
  fault_e           code_q, code_d, flt;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             g2_q, dr_q, run_q, flt_q;
  logic             g2_tmo, dr_tmo;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    g2_tmo  = g2_n && timer_q >= G2_LIM;
    dr_tmo  = dr_n && timer_q >= DR_LIM;
    flt     = state_q == G2_ON ? (perm_n ? FLT_PERM_LOST : g2_tmo ? FLT_G2_TMO : FLT_NONE) :
              state_q == DR_ON ? (perm_n ? FLT_PERM_LOST : g2_n ? FLT_G2_LOST :
                                  dr_tmo ? FLT_DR_TMO : FLT_NONE) :
              state_q == RUN   ? (perm_n ? FLT_PERM_LOST : g2_n ? FLT_G2_LOST :
                                  dr_n ? FLT_DR_LOST : FLT_NONE) : FLT_NONE;
    case (state_q)
      IDLE: if (on_req && !off_req) begin
        state_d = perm_n ? FAULT : G2_ON;
        code_d  = perm_n ? FLT_NO_PERM : FLT_NONE;
      end
      G2_ON, DR_ON, RUN: begin
        if (flt != FLT_NONE) begin
          state_d = FAULT;
          code_d  = flt;
        end else if (off_req) state_d = SHUTDOWN;
        else if (state_q == G2_ON && !g2_n) state_d = DR_ON;
        else if (state_q == DR_ON && !dr_n) state_d = RUN;
      end
      SHUTDOWN: if (timer_q >= OFF_LIM) state_d = IDLE;
      FAULT: if (fault_clr && !perm_n) begin
        state_d = IDLE;
        code_d  = FLT_NONE;
      end
      default: state_d = IDLE;
    endcase
    timer_d = state_d != state_q ? '0 : &timer_q ? timer_q : timer_q + 1'b1;
  end

  // Enables are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= FLT_NONE;
      timer_q <= '0;
      g2_q    <= 1'b0;
      dr_q    <= 1'b0;
      run_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      g2_q    <= state_d inside {G2_ON, DR_ON, RUN, SHUTDOWN};
      dr_q    <= state_d inside {DR_ON, RUN};
      run_q   <= state_d == RUN;
      flt_q   <= state_d == FAULT;
    end
  end

  assign g2_ps_act  = g2_q;
  assign dr_amp     = dr_q;
  assign running    = run_q;
  assign fault      = flt_q;
  assign fault_code = code_q;
  assign state      = state_q;
endmodule

// File: tb/tb_rpsc_startup_sequencer.sv
// tb_rpsc_startup_sequencer: scoreboard bench for the startup sequencer with short timeouts.
module tb_rpsc_startup_sequencer;
  localparam int G2T = 16, DRT = 8, OFFD = 4, DEB = 4;
`ifdef RPSC_SEQ_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int DR_DLY = LAT == 3 ? 3 : 0;
  localparam int S_IDLE = 0, S_G2 = 1, S_DR = 2, S_RUN = 3, S_SD = 4, S_FLT = 5;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       on_req = 1'b0, off_req = 1'b0, fault_clr = 1'b0;
  logic       perm_n = 1'b0, g2_n = 1'b1, dr_n = 1'b1;
  logic       g2_ps_act, dr_amp, running, fault;
  logic [2:0] fault_code, state;

  rpsc_startup_sequencer #(
    .G2_TMO(G2T), .DR_TMO(DRT), .OFF_DLY(OFFD), .DEB_LEN(DEB)
  ) dut (
    .clk(clk), .reset(rst_n), .on_req(on_req), .off_req(off_req), .fault_clr(fault_clr),
    .not_on_perm(perm_n), .not_g2_ok(g2_n), .not_dr_amp_ok(dr_n),
    .g2_ps_act(g2_ps_act), .dr_amp(dr_amp), .running(running), .fault(fault),
    .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sbq[$];
  int  vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got g2/dr/run/flt/code/st=%b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ev(input int st, input int code);
    logic [2:0] s, c;
    s = 3'(st);
    c = 3'(code);
    return {st >= 1 && st <= 4, st == 2 || st == 3, st == 3, st == 5, c, s};
  endfunction

  function automatic logic [9:0] obs();
    return {g2_ps_act, dr_amp, running, fault, fault_code, state};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp();
    sb_t e;
    e = sbq.pop_front();
    chk(e.tag, obs(), e.exp);
  endtask

  task automatic expect_after(input string tag, input int st, input int code, input int n);
    sbq.push_back('{tag, ev(st, code)});
    step(n);
    pop_cmp();
  endtask

  task automatic wait_state(input string tag, input int st, input int code, input int budget);
    sbq.push_back('{tag, ev(st, code)});
    for (int i = 0; i < budget && state !== 3'(st); i++) step(1);
    pop_cmp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    expect_after("reset", S_IDLE, 0, 2);
    rst_n = 1'b1;
    expect_after("idle", S_IDLE, 0, LAT + 1);
    on_req = 1'b1; off_req = 1'b1;
    expect_after("on_off_idle", S_IDLE, 0, 1);
    on_req = 1'b0; off_req = 1'b0;
    // normal start
    on_req = 1'b1;
    expect_after("g2_on", S_G2, 0, 1);
    on_req = 1'b0;
    step(4);
    g2_n = 1'b0;
    expect_after("g2_wait", S_G2, 0, LAT - 1);
    expect_after("dr_on", S_DR, 0, 1);
    step(DR_DLY);
    dr_n = 1'b0;
    expect_after("run", S_RUN, 0, LAT);
    // shutdown
    off_req = 1'b1;
    expect_after("sd_entry", S_SD, 0, 1);
    off_req = 1'b0;
    expect_after("sd_hold", S_SD, 0, 3);
    expect_after("sd_idle", S_IDLE, 0, 1);
    g2_n = 1'b1; dr_n = 1'b1;
    step(LAT + 1);
    // G2 timeout
    on_req = 1'b1;
    expect_after("g2_start", S_G2, 0, 1);
    on_req = 1'b0;
    expect_after("g2_edge", S_G2, 0, G2T - 1);
    expect_after("g2_tmo", S_FLT, 3, 1);
    fault_clr = 1'b1;
    expect_after("clr3", S_IDLE, 0, 1);
    fault_clr = 1'b0;
    // no permission at start
    perm_n = 1'b1;
    step(LAT);
    on_req = 1'b1;
    expect_after("no_perm", S_FLT, 1, 1);
    on_req = 1'b0; perm_n = 1'b0;
    step(LAT);
    fault_clr = 1'b1;
    expect_after("clr1", S_IDLE, 0, 1);
    fault_clr = 1'b0;
    // drive-amp ready on the same cycle the DR timer reaches DR_TMO-1
    on_req = 1'b1;
    expect_after("g2_5a", S_G2, 0, 1);
    on_req = 1'b0; g2_n = 1'b0;
    expect_after("dr_5a", S_DR, 0, LAT);
    step(DRT - LAT);
    dr_n = 1'b0;
    expect_after("dr_t6", S_DR, 0, LAT - 1);
    expect_after("run_t7", S_RUN, 0, 1);
    // permission lost in RUN
    perm_n = 1'b1;
    expect_after("run_perm_pre", S_RUN, 0, LAT - 1);
    expect_after("perm_lost", S_FLT, 2, 1);
    fault_clr = 1'b1;
    expect_after("clr_noperm", S_FLT, 2, 2);
    on_req = 1'b1;
    expect_after("flt_on_ign", S_FLT, 2, 1);
    on_req = 1'b0; perm_n = 1'b0;
    expect_after("clr_perm_ok", S_IDLE, 0, LAT);
    fault_clr = 1'b0; g2_n = 1'b1; dr_n = 1'b1;
    step(LAT + 1);
    // DR timeout
    on_req = 1'b1;
    expect_after("g2_i", S_G2, 0, 1);
    on_req = 1'b0; g2_n = 1'b0;
    expect_after("dr_i", S_DR, 0, LAT);
    expect_after("dr_hold", S_DR, 0, DRT - 1);
    expect_after("dr_tmo", S_FLT, 4, 1);
    fault_clr = 1'b1;
    expect_after("clr4", S_IDLE, 0, 1);
    fault_clr = 1'b0;
    // G2 lost together with off_req
    on_req = 1'b1;
    expect_after("g2_j", S_G2, 0, 1);
    on_req = 1'b0; dr_n = 1'b0;
    wait_state("run_j", S_RUN, 0, 20);
    g2_n = 1'b1;
    step(LAT - 1);
    off_req = 1'b1;
    expect_after("g2_lost_off", S_FLT, 5, 1);
    off_req = 1'b0; fault_clr = 1'b1;
    expect_after("clr5", S_IDLE, 0, 1);
    fault_clr = 1'b0; g2_n = 1'b0;
    step(LAT + 1);
    on_req = 1'b1;
    step(1);
    on_req = 1'b0;
    wait_state("run_k", S_RUN, 0, 20);
`ifdef RPSC_SEQ_DEBOUNCE_EN
    g2_n = 1'b1;
    step(2);
    g2_n = 1'b0;
    expect_after("glitch", S_RUN, 0, LAT + 4);
`endif
    // asynchronous reset in RUN
    sbq.push_back('{"async_rst", ev(S_IDLE, 0)});
    #2 rst_n = 1'b0;
    #1 pop_cmp();
    step(2);
    rst_n = 1'b1;
    step(LAT + 1);
    on_req = 1'b1;
    step(1);
    on_req = 1'b0;
    wait_state("run_l", S_RUN, 0, 20);
    dr_n = 1'b1;
    expect_after("dr_lost", S_FLT, 6, LAT);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
